inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, meaning the number of instruction buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-005 The block SHALL have port redirect_valid, input, 1, a jump/branch redirect request from execute.
REQ-006 The block SHALL have port redirect_pc, input, 64, the redirect target.
REQ-007 The block SHALL have port mem_req_valid, output, 1, meaning a fetch request is pending.
REQ-008 The block SHALL have port mem_req_ready, input, 1, meaning the memory accepts the request.
REQ-009 The block SHALL have port mem_req_addr, output, 64, the fetch address, always 4-byte aligned.
REQ-010 The block SHALL have port mem_resp_valid, input, 1, meaning the response data is valid (always accepted).
REQ-011 The block SHALL have port mem_resp_data, input, 32, the fetched instruction word.
REQ-012 The block SHALL have port inst_valid, output, 1, meaning the buffer head holds an instruction.
REQ-013 The block SHALL have port inst_ready, input, 1, meaning the decoder consumes the head this cycle.
REQ-014 The block SHALL have port inst, output, 32, the head instruction word.
REQ-015 The block SHALL have port inst_pc, output, 64, the address of the head instruction.

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, WAIT; at most one memory request SHALL be outstanding.
REQ-017 In IDLE, the block SHALL move to REQ when count < BUF_DEPTH and no redirect is present this cycle.
REQ-018 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal fpc; both SHALL remain stable until mem_req_valid && mem_req_ready.
REQ-019 On the request handshake, the block SHALL go to WAIT, latch the request address as resp_pc, and set fpc <= fpc + 4 (64-bit wrap).
REQ-020 In WAIT, mem_resp_valid SHALL write {mem_resp_data, resp_pc} into the buffer tail unless drop=1; the FSM SHALL then go to IDLE, or to REQ if a slot remains free after that write (count after update < BUF_DEPTH).
REQ-021 mem_resp_valid outside WAIT SHALL be ignored.
REQ-022 The buffer SHALL be FIFO; inst/inst_pc SHALL show the head; inst_valid = (count != 0); a head pop SHALL occur on inst_valid && inst_ready.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; the pointers SHALL wrap modulo BUF_DEPTH.
REQ-024 A request SHALL be issued only if count + outstanding < BUF_DEPTH, so that a response never overflows the buffer.
REQ-025 On redirect_valid: the buffer SHALL be flushed (count=0, pointers=0), fpc <= {redirect_pc[63:2], 2'b00}, and redirect SHALL take priority over same-cycle push and pop.
REQ-026 A redirect in WAIT, or in REQ on the same cycle as or before the handshake, SHALL set drop=1; the next response SHALL then be discarded, drop SHALL clear, and the FSM SHALL continue from the new fpc.
REQ-027 A redirect in REQ without a handshake SHALL keep the old address asserted until accepted (no withdrawal), with drop=1 and the fpc update deferred to the handshake cycle (fpc <= redirect target, not +4).
REQ-028 A redirect in the same cycle as a response SHALL discard that response.
REQ-029 Latency SHALL be: request at cycle N, response at N+k, with inst_valid=1 at N+k+1.

Reset
REQ-030 While rst=1, the block SHALL set fpc=RESET_PC, state=IDLE, count=0, pointers=0, drop=0, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0; rst SHALL override redirect and memory inputs.
REQ-031 A reset mid-request SHALL abandon the outstanding transaction without dropping an extra later response; the memory is reset together with the block.
REQ-032 The first request SHALL appear in the second cycle after rst deasserts (IDLE->REQ), with address RESET_PC.

Verification
REQ-033 Reset, mem_req_ready=1, 1-cycle response 32'h00000013 -> mem_req_addr=80000000, inst_valid with inst=00000013 and inst_pc=80000000, next request 80000004.
REQ-034 Hold inst_ready=0 for 6 responses -> exactly 2 buffered (80000000, 80000004), mem_req_valid=0; a single pop -> exactly one new request, to 80000008.
REQ-035 Redirect to 64'h80001003 while in WAIT -> the pending response is dropped, the next request goes to 80001000, and inst_pc of the next instruction is 80001000.
REQ-036 mem_req_ready=0 for 5 cycles with a redirect in cycle 2 -> the address stays stable at the old value, the accepted response is dropped, and the next address is the redirect target.
REQ-037 Redirect, push and pop in the same cycle -> count=0 next cycle, and no instruction from the old stream is ever presented.
REQ-038 rst asserted in WAIT -> all outputs are at reset values the next cycle, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: a single-outstanding request FSM feeding a small FIFO
// of {instruction, pc} pairs, with redirect flush and stale-response dropping.
module inst_fetch #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);
   localparam logic [63:0] RESET_PC_A = {RESET_PC[63:2], 2'b00};

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state_reg, state_next;
   logic [63:0]     fpc_reg, fpc_next;
   logic [63:0]     resp_pc_reg, resp_pc_next;
   logic [63:0]     redir_pc_reg, redir_pc_next;
   logic            redir_pend_reg, redir_pend_next;
   logic            drop_reg, drop_next;
   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [PW:0]     count_reg, count_next;

   logic [31:0]     buf_inst [BUF_DEPTH];
   logic [63:0]     buf_pc   [BUF_DEPTH];

   logic [63:0]     redir_target;
   logic            push;
   logic            pop;
   logic            unused_ok;

   assign redir_target = {redirect_pc[63:2], 2'b00};
   assign unused_ok    = ^redirect_pc[1:0];

   assign inst_valid    = (count_reg != '0);
   assign pop           = inst_valid && inst_ready && !redirect_valid;
   assign push          = (state_reg == WAIT) && mem_resp_valid && !drop_reg && !redirect_valid;
   assign mem_req_valid = (state_reg == REQ);
   assign mem_req_addr  = fpc_reg;
   assign inst          = inst_valid ? buf_inst[head_reg] : '0;
   assign inst_pc       = inst_valid ? buf_pc[head_reg]   : '0;

   always_comb begin
      state_next      = state_reg;
      fpc_next        = fpc_reg;
      resp_pc_next    = resp_pc_reg;
      redir_pc_next   = redir_pc_reg;
      redir_pend_next = redir_pend_reg;
      drop_next       = drop_reg;
      head_next       = pop  ? head_reg + PW'(1) : head_reg;
      tail_next       = push ? tail_reg + PW'(1) : tail_reg;
      count_next      = count_reg + (PW+1)'(push) - (PW+1)'(pop);

      // A redirect empties the buffer before any push/pop of this cycle lands.
      if (redirect_valid) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end

      case (state_reg)
         IDLE: begin
            if (redirect_valid)
               fpc_next = redir_target;
            else if (count_reg < DEPTH_C)
               state_next = REQ;
         end
         REQ: begin
            if (mem_req_ready) begin
               state_next      = WAIT;
               resp_pc_next    = fpc_reg;
               redir_pend_next = 1'b0;
               if (redirect_valid) begin
                  fpc_next  = redir_target;
                  drop_next = 1'b1;
               end else if (redir_pend_reg) begin
                  fpc_next = redir_pc_reg;
               end else begin
                  fpc_next = fpc_reg + 64'd4;
               end
            end else if (redirect_valid) begin
               // The presented address cannot be withdrawn; remember the target.
               drop_next       = 1'b1;
               redir_pend_next = 1'b1;
               redir_pc_next   = redir_target;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               drop_next  = 1'b0;
               state_next = (count_next < DEPTH_C) ? REQ : IDLE;
               if (redirect_valid)
                  fpc_next = redir_target;
            end else if (redirect_valid) begin
               drop_next = 1'b1;
               fpc_next  = redir_target;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         fpc_reg        <= RESET_PC_A;
         resp_pc_reg    <= '0;
         redir_pc_reg   <= '0;
         redir_pend_reg <= 1'b0;
         drop_reg       <= 1'b0;
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         fpc_reg        <= fpc_next;
         resp_pc_reg    <= resp_pc_next;
         redir_pc_reg   <= redir_pc_next;
         redir_pend_reg <= redir_pend_next;
         drop_reg       <= drop_next;
         head_reg       <= head_next;
         tail_reg       <= tail_next;
         count_reg      <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         buf_inst[tail_reg] <= mem_resp_data;
         buf_pc[tail_reg]   <= resp_pc_reg;
      end
   end
endmodule
